// File: rtl/calc_input_frontend_pkg.sv
// Shared encodings for the calculator front end: debounce FSM states and the
// one-hot function select order consumed by the calculator select logic.
package calc_input_frontend_pkg;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int FN_NUM = 4;
  localparam int FN_ADD = 0;
  localparam int FN_CMP = 1;
  localparam int FN_MAX = 2;
  localparam int FN_MIN = 3;

  typedef logic [FN_NUM-1:0] fn_onehot_t;

  // Lowest index wins, so add beats cmp beats max beats min.
  function automatic fn_onehot_t fn_priority_pick(input fn_onehot_t req);
    fn_onehot_t pick;
    pick = '0;
    for (int i = FN_NUM - 1; i >= 0; i--) begin
      if (req[i]) pick = fn_onehot_t'(1) << i;
    end
    return pick;
  endfunction

endpackage

// File: rtl/calc_input_frontend_key_debounce.sv
// One function key: 2-FF synchronizer, optional polarity flip, and a
// press/release debounce FSM that emits a registered one-cycle press pulse.
module key_debounce
  import calc_input_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_p0;
  logic             key_p1;
  logic             key_sync;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;

  // Sync stage: flops rest at the released raw level so an active-low key
  // never looks pressed straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_p0 <= KEY_ACTIVE_LOW;
      key_p1 <= KEY_ACTIVE_LOW;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
    end
  end

  assign key_sync = key_p1 ^ KEY_ACTIVE_LOW;

  // Debounce stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      DB_IDLE: begin
        if (key_sync) begin
          state_nxt = DB_PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      DB_PRESS_WAIT: begin
        if (!key_sync) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DB_PRESSED: begin
        if (!key_sync) begin
          state_nxt = DB_RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      DB_RELEASE_WAIT: begin
        if (key_sync) begin
          state_nxt = DB_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == DB_PRESSED) || (state == DB_RELEASE_WAIT);

endmodule

// File: rtl/calc_input_frontend.sv
// Calculator input front end: debounced function keys select a one-hot
// function and latch both synchronized operand banks on each accepted press.
module calc_input_frontend
  import calc_input_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int KEY_ACTIVE_LOW  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic       key_add,
  input  logic       key_cmp,
  input  logic       key_max,
  input  logic       key_min,
  output logic [3:0] din1,
  output logic [3:0] din2,
  output logic       b_add,
  output logic       b_cmp,
  output logic       b_max,
  output logic       b_min,
  output logic       op_strobe
);

  fn_onehot_t key_raw;
  fn_onehot_t key_press;
  fn_onehot_t key_level_unused;
  fn_onehot_t fn_sel;
  logic [3:0] sw_a_p0;
  logic [3:0] sw_a_p1;
  logic [3:0] sw_b_p0;
  logic [3:0] sw_b_p1;

  assign key_raw[FN_ADD] = key_add;
  assign key_raw[FN_CMP] = key_cmp;
  assign key_raw[FN_MAX] = key_max;
  assign key_raw[FN_MIN] = key_min;

  for (genvar k = 0; k < FN_NUM; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW != 0)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .key_raw (key_raw[k]),
      .level   (key_level_unused[k]),
      .press   (key_press[k])
    );
  end

  // Operand sync stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_a_p0 <= '0;
      sw_a_p1 <= '0;
      sw_b_p0 <= '0;
      sw_b_p1 <= '0;
    end else begin
      sw_a_p0 <= sw_a;
      sw_a_p1 <= sw_a_p0;
      sw_b_p0 <= sw_b;
      sw_b_p1 <= sw_b_p0;
    end
  end

  // Capture stage: one capture per cycle regardless of how many keys fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      din1      <= '0;
      din2      <= '0;
      fn_sel    <= '0;
      op_strobe <= 1'b0;
    end else begin
      op_strobe <= |key_press;
      if (|key_press) begin
        din1   <= sw_a_p1;
        din2   <= sw_b_p1;
        fn_sel <= fn_priority_pick(key_press);
      end
    end
  end

  assign b_add = fn_sel[FN_ADD];
  assign b_cmp = fn_sel[FN_CMP];
  assign b_max = fn_sel[FN_MAX];
  assign b_min = fn_sel[FN_MIN];

endmodule

// File: tb/tb_calc_input_frontend.sv
// Bench for calc_input_frontend: directed latency/priority scenarios plus random
// key activity against a run-length debounce model; second DUT is active-low.
module tb_calc_input_frontend;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_a = '0, sw_b = '0;
  logic       key_add = 0, key_cmp = 0, key_max = 0, key_min = 0;
  logic [3:0] din1, din2;
  logic       b_add, b_cmp, b_max, b_min, op_strobe;

  logic       key_add_n = 1, key_cmp_n = 1, key_max_n = 1, key_min_n = 1;
  logic [3:0] din1_n, din2_n;
  logic       b_add_n, b_cmp_n, b_max_n, b_min_n, op_strobe_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_input_frontend #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .KEY_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b),
    .key_add(key_add), .key_cmp(key_cmp), .key_max(key_max), .key_min(key_min),
    .din1(din1), .din2(din2), .b_add(b_add), .b_cmp(b_cmp), .b_max(b_max),
    .b_min(b_min), .op_strobe(op_strobe));

  calc_input_frontend #(.DEBOUNCE_CYCLES(DB), .CNT_W(4), .KEY_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b),
    .key_add(key_add_n), .key_cmp(key_cmp_n), .key_max(key_max_n), .key_min(key_min_n),
    .din1(din1_n), .din2(din2_n), .b_add(b_add_n), .b_cmp(b_cmp_n), .b_max(b_max_n),
    .b_min(b_min_n), .op_strobe(op_strobe_n));

  // Reference model: a key level flips once the synchronized input has
  // disagreed with it for DB consecutive samples; a flip to pressed is an
  // event, and the cycle after an event the operands and selection are latched.
  logic [3:0] ms1, ms2, mlvl, mev;
  int         mrun[4];
  logic [3:0] msa1, msa2, msb1, msb2, mdin1, mdin2, msel;
  logic       mstrobe;

  task automatic model_step();
    logic [3:0] raw, ev_new;
    raw = {key_min, key_max, key_cmp, key_add};
    if (rst) begin
      ms1 = 0; ms2 = 0; mlvl = 0; mev = 0;
      msa1 = 0; msa2 = 0; msb1 = 0; msb2 = 0;
      mdin1 = 0; mdin2 = 0; msel = 0; mstrobe = 0;
      for (int k = 0; k < 4; k++) mrun[k] = 0;
    end else begin
      mstrobe = |mev;
      if (|mev) begin
        mdin1 = msa2;
        mdin2 = msb2;
        msel  = 0;
        for (int k = 3; k >= 0; k--) if (mev[k]) msel = 4'b0001 << k;
      end
      ev_new = 0;
      for (int k = 0; k < 4; k++) begin
        if (ms2[k] != mlvl[k]) begin
          mrun[k]++;
          if (mrun[k] == DB) begin
            mlvl[k]   = ms2[k];
            mrun[k]   = 0;
            ev_new[k] = ms2[k];
          end
        end else begin
          mrun[k] = 0;
        end
      end
      mev = ev_new;
      ms2 = ms1; ms1 = raw;
      msa2 = msa1; msa1 = sw_a;
      msb2 = msb1; msb1 = sw_b;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [12:0] dut_out();
    return {din1, din2, b_min, b_max, b_cmp, b_add, op_strobe};
  endfunction

  function automatic logic [12:0] model_out();
    return {mdin1, mdin2, msel, mstrobe};
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) begin
      sw_a = 4'($urandom); sw_b = 4'($urandom);
      tick();
      checks++;
      if (dut_out() !== 13'h0) begin
        failures++; $display("FAIL reset_vals got=%h want=0", dut_out());
      end
    end
    rst = 0;
    repeat (20) begin
      sw_a = 4'($urandom); sw_b = 4'($urandom);
      tick();
      checks++;
      if (dut_out() !== 13'h0) begin
        failures++; $display("FAIL idle_zero got=%h want=0", dut_out());
      end
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL idle_model got=%h want=%h", dut_out(), model_out());
      end
    end
  endtask

  task automatic test_add_capture();
    int strobes = 0;
    sw_a = 4'h9; sw_b = 4'h3; key_add = 1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      strobes += int'(op_strobe);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL add_model n=%0d got=%h want=%h", n, dut_out(), model_out());
      end
      if (n == 6) begin
        checks++;
        if ({b_add, op_strobe} !== 2'b00) begin
          failures++; $display("FAIL add_early got=%b want=00", {b_add, op_strobe});
        end
      end
      if (n == 7) begin
        checks++;
        if ({b_add, din1, din2, op_strobe} !== {1'b1, 4'h9, 4'h3, 1'b1}) begin
          failures++; $display("FAIL add_latency got=%b/%h/%h/%b want=1/9/3/1", b_add, din1, din2, op_strobe);
        end
      end
      if (n == 8) sw_a = 4'hF;
    end
    checks++;
    if (din1 !== 4'h9 || strobes != 1) begin
      failures++; $display("FAIL add_hold din1=%h strobes=%0d want 9 and 1", din1, strobes);
    end
    key_add = 0;
    repeat (10) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL add_release got=%h want=%h", dut_out(), model_out());
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      key_cmp = (i % 2 == 0);
      tick();
      checks++;
      if ({op_strobe, b_add} !== 2'b01) begin
        failures++; $display("FAIL bounce_reject strobe/add got=%b want=01", {op_strobe, b_add});
      end
    end
    key_cmp = 1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL cmp_model n=%0d got=%h want=%h", n, dut_out(), model_out());
      end
      if (n == 6) begin
        checks++;
        if (b_cmp !== 1'b0) begin
          failures++; $display("FAIL cmp_early got=%b want=0", b_cmp);
        end
      end
      if (n == 7) begin
        checks++;
        if ({b_cmp, b_add, op_strobe} !== 3'b101) begin
          failures++; $display("FAIL cmp_latency got=%b want=101", {b_cmp, b_add, op_strobe});
        end
      end
    end
    key_cmp = 0;
    repeat (10) tick();
  endtask

  task automatic test_simultaneous();
    int strobes = 0;
    sw_a = 4'($urandom); sw_b = 4'($urandom);
    key_max = 1; key_min = 1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      strobes += int'(op_strobe);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL simul_model n=%0d got=%h want=%h", n, dut_out(), model_out());
      end
      if (n == 7) begin
        checks++;
        if ({b_max, b_min, b_cmp, op_strobe} !== 4'b1001) begin
          failures++; $display("FAIL simul_priority got=%b want=1001", {b_max, b_min, b_cmp, op_strobe});
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      failures++; $display("FAIL simul_single strobes=%0d want=1", strobes);
    end
    key_max = 0; key_min = 0;
    repeat (10) tick();
  endtask

  task automatic test_reset_abort();
    key_min = 1;
    repeat (4) tick();
    rst = 1;
    repeat (2) begin
      tick();
      checks++;
      if (dut_out() !== 13'h0) begin
        failures++; $display("FAIL abort_reset got=%h want=0", dut_out());
      end
    end
    rst = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL abort_model n=%0d got=%h want=%h", n, dut_out(), model_out());
      end
      if (n == 6) begin
        checks++;
        if (b_min !== 1'b0) begin
          failures++; $display("FAIL abort_early got=%b want=0", b_min);
        end
      end
      if (n == 7) begin
        checks++;
        if ({b_min, op_strobe} !== 2'b11) begin
          failures++; $display("FAIL abort_relatch got=%b want=11", {b_min, op_strobe});
        end
      end
    end
  endtask

  task automatic test_repress();
    int strobes = 0;
    logic [3:0] a, b;
    repeat (30) begin
      tick();
      strobes += int'(op_strobe);
    end
    checks++;
    if (strobes != 0) begin
      failures++; $display("FAIL hold_norepeat strobes=%0d want=0", strobes);
    end
    key_min = 0;
    repeat (12) tick();
    a = 4'($urandom); b = 4'($urandom);
    sw_a = a; sw_b = b; key_min = 1;
    repeat (12) begin
      tick();
      strobes += int'(op_strobe);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL repress_model got=%h want=%h", dut_out(), model_out());
      end
    end
    checks++;
    if ({din1, din2, b_min} !== {a, b, 1'b1} || strobes != 1) begin
      failures++; $display("FAIL repress got=%h/%h/%b strobes=%0d want=%h/%h/1 and 1", din1, din2, b_min, strobes, a, b);
    end
    key_min = 0;
    repeat (12) tick();
  endtask

  task automatic test_random();
    logic [3:0] k;
    int strobes = 0;
    k = 0;
    repeat (600) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) k[i] = ~k[i];
      {key_min, key_max, key_cmp, key_add} = k;
      sw_a = 4'($urandom); sw_b = 4'($urandom);
      tick();
      strobes += int'(op_strobe);
      checks++;
      if (dut_out() !== model_out()) begin
        failures++; $display("FAIL random_model got=%h want=%h", dut_out(), model_out());
      end
    end
    {key_min, key_max, key_cmp, key_add} = 4'b0;
    repeat (15) tick();
    $display("random phase strobes=%0d", strobes);
  endtask

  task automatic test_active_low();
    int strobes = 0;
    sw_a = 4'h6; sw_b = 4'hA;
    key_add_n = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      strobes += int'(op_strobe_n);
      if (n == 6) begin
        checks++;
        if ({b_add_n, op_strobe_n} !== 2'b00) begin
          failures++; $display("FAIL low_early got=%b want=00", {b_add_n, op_strobe_n});
        end
      end
      if (n == 7) begin
        checks++;
        if ({b_add_n, op_strobe_n, din1_n, din2_n} !== {2'b11, 4'h6, 4'hA}) begin
          failures++; $display("FAIL low_latency got=%b%b/%h/%h want=11/6/a", b_add_n, op_strobe_n, din1_n, din2_n);
        end
      end
    end
    checks++;
    if (strobes != 1 || {b_add_n, b_cmp_n, b_max_n, b_min_n} !== 4'b1000) begin
      failures++; $display("FAIL low_single strobes=%0d sel=%b want 1 and 1000", strobes, {b_add_n, b_cmp_n, b_max_n, b_min_n});
    end
    key_add_n = 1;
  endtask

  initial begin
    test_reset();
    test_add_capture();
    test_bounce();
    test_simultaneous();
    test_reset_abort();
    test_repress();
    test_random();
    test_active_low();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
